sync_fifo_burst_reader: RTL and testbench
=========================================

Name: sync_fifo_burst_reader

Overview:
- Read-side companion to the team's synchronous RAM FIFO. Drains the FIFO's look-ahead read port and presents the words as a registered valid/ready stream, grouped into bursts with a last-word marker.
- A burst starts when occupancy reaches BURST_LEN. A partial burst is flushed if data sits below threshold for TIMEOUT cycles.
- Sits between a producer FIFO and a bus master or serializer that prefers bursts.

Parameters:
- DWIDTH, 16: data word width; must equal the FIFO's DWIDTH.
- AWIDTH, 4: FIFO address width; occupancy input is AWIDTH+1 bits.
- BURST_LEN, 8: words per full burst; legal range 1..2**AWIDTH.
- TIMEOUT, 255: cycles a partial fill may wait before being flushed; 0 disables flushing.

Ports:
- clk, input, 1: sole clock, rising edge.
- srst, input, 1: reset. Synchronous and active-high.
- enable, input, 1: permits new bursts to start; does not abort a burst in progress.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_dcount, input, AWIDTH+1: FIFO occupancy.
- fifo_dout_comb, input, DWIDTH: FIFO look-ahead data at the current read address.
- fifo_re, output, 1: FIFO read enable, combinational from registered state.
- m_valid, output, 1: stream word valid.
- m_ready, input, 1: stream sink ready.
- m_data, output, DWIDTH: stream word.
- m_last, output, 1: marks the final word of a burst.
- busy, output, 1: high while state is not IDLE.

Behaviour:
- Reset: on srst high at a clock edge:
  - state=IDLE, timer=0, remaining=0;
  - m_valid=0, m_data=0, m_last=0, busy=0, fifo_re=0.
  - Reset mid-burst discards the word in the output register. Unread FIFO words are untouched.
- States: IDLE, WAIT, BURST.
- IDLE:
  - If enable and dcount>=BURST_LEN: go to BURST with remaining=BURST_LEN.
  - Else if enable and dcount!=0: go to WAIT with timer=0.
- WAIT:
  - If dcount>=BURST_LEN: go to BURST with remaining=BURST_LEN. Threshold has priority over timeout when both are true in the same cycle.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: go to BURST with remaining=dcount (flush).
  - Else if enable is low: return to IDLE.
  - Otherwise timer increments.
- Read enable:
  - In BURST, fifo_re = ~fifo_empty & (remaining!=0) & (~m_valid | m_ready).
  - The empty guard is redundant by construction and is retained.
- On fifo_re:
  - m_data <= fifo_dout_comb, m_valid <= 1, remaining decrements.
  - m_last <= (remaining==1).
- Leaving BURST: when fifo_re occurs with remaining==1, go to IDLE in the same edge. The output register may still hold the last word; the next burst's first read waits for that slot to free.
- Output register:
  - m_valid clears on m_ready & m_valid & ~fifo_re.
  - m_data and m_last hold while m_valid & ~m_ready.
  - No combinational path from m_ready to m_valid or m_data. There is a combinational path from m_ready to fifo_re.
- Throughput: one word per cycle with m_ready held high.
- Latency: threshold met in IDLE at cycle N gives BURST and first fifo_re at N+1, and first m_valid at N+2.
- Concurrent FIFO writes during a burst raise dcount. They do not extend the current burst; the surplus is handled by the next IDLE decision.
- Widths:
  - remaining is AWIDTH+1 bits.
  - timer is $clog2(TIMEOUT+1) bits, minimum 1.
  - All compares are unsigned at AWIDTH+1 bits.

Decomposition:
- Package sync_fifo_burst_pkg holds:
  - the state enum typedef (IDLE/WAIT/BURST);
  - a dcount_t typedef parameterised by AWIDTH, or localparams derived in-module.
- One natural sub-module: stream_out_slot, the single-entry registered valid/ready output stage. It outputs a take-permit signal (~m_valid | m_ready).

Test Plan:
- BURST_LEN=8; preload 8 words 0x0100..0x0107; enable=1; m_ready=1.
  - fifo_re high for 8 consecutive cycles.
  - m_data 0x0100..0x0107 on consecutive cycles.
  - m_last only with 0x0107; busy falls the cycle after the 8th read.
- Same preload with m_ready toggling 1,0,1,0.
  - All 8 words delivered once, in order.
  - fifo_re never high while m_valid & ~m_ready; m_last still on 0x0107.
- TIMEOUT=16; write 3 words 0xA0..0xA2 then stop.
  - WAIT for 16 cycles, then a 3-word burst; m_last on 0xA2.
- In WAIT at timer=5, the writer raises dcount to 8.
  - Full 8-word burst starts the next cycle; no flush occurs.
- FIFO receives 4 extra writes during a burst (dcount peaks at 12).
  - Burst ends after exactly 8 words, then WAIT, then a flush of 4 words.
- srst pulsed after the 3rd word of a burst.
  - Next cycle: m_valid=0, fifo_re=0, busy=0.
  - After release with dcount=5 and enable=1: state goes to WAIT.

Source files
------------

// File: rtl/sync_fifo_burst_pkg.sv
// Shared types and helpers for the burst reader that drains the synchronous RAM FIFO.
package sync_fifo_burst_pkg;

  // Reader control states: idle, filling below threshold, and draining a burst.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  // Width of the partial-fill timer. A disabled timeout still gets a 1-bit counter.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_fifo_burst_reader_stream_out_slot.sv
// Single-entry registered valid/ready output stage.
// Holds one word until the sink takes it, and tells the reader when a new word may be loaded.
module stream_out_slot #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_load,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              o_take_ok
);

  logic              r_valid;
  logic [DWIDTH-1:0] r_data;
  logic              r_last;

  // Slot is free when empty, or when its current word leaves this cycle.
  assign o_take_ok = ~r_valid | m_ready;

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_last  = r_last;

  // Load a new word, or retire the held word on a handshake; otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the data register is reset too because the reset value is observable.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid && m_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Burst reader: drains the FIFO look-ahead port into a registered valid/ready stream,
// grouping words into BURST_LEN bursts and flushing stale partial fills after TIMEOUT cycles.
module sync_fifo_burst_reader
  import sync_fifo_burst_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [AWIDTH:0]   fifo_dcount,
  input  logic [DWIDTH-1:0] fifo_dout_comb,
  output logic              fifo_re,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int CW = AWIDTH + 1;
  localparam int TW = timer_width(TIMEOUT);

  localparam logic [CW-1:0] LEN_C    = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit            FLUSH_EN = (TIMEOUT != 0);

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [CW-1:0]   r_remaining;

  logic            w_take_ok;
  logic            w_fifo_re;
  logic            w_last;

  // The empty guard is redundant while remaining never exceeds occupancy; kept as a safety net.
  assign w_fifo_re = (r_state == BURST) & ~fifo_empty & (r_remaining != '0) & w_take_ok;
  assign w_last    = (r_remaining == CW'(1));

  assign fifo_re = w_fifo_re;
  assign busy    = (r_state != IDLE);

  // Burst control: decide when to start a full burst or flush, and count words out.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable && (fifo_dcount >= LEN_C)) begin
            r_state     <= BURST;
            r_remaining <= LEN_C;
          end else if (enable && (fifo_dcount != '0)) begin
            r_state <= WAIT;
            r_timer <= '0;
          end
        end
        WAIT: begin
          // Reaching the threshold wins over an expiring timer in the same cycle.
          if (fifo_dcount >= LEN_C) begin
            r_state     <= BURST;
            r_remaining <= LEN_C;
          end else if (FLUSH_EN && (r_timer == TMR_LAST)) begin
            r_state     <= BURST;
            r_remaining <= fifo_dcount;
          end else if (!enable) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        BURST: begin
          // Words written during the burst are left for the next IDLE decision.
          if (w_fifo_re) begin
            r_remaining <= r_remaining - CW'(1);
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_out_slot #(
    .DWIDTH(DWIDTH)
  ) u_slot (
    .clk      (clk),
    .srst     (srst),
    .i_load   (w_fifo_re),
    .i_data   (fifo_dout_comb),
    .i_last   (w_last),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .o_take_ok(w_take_ok)
  );

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Directed bench for sync_fifo_burst_reader with a small look-ahead FIFO model.
module tb_sync_fifo_burst_reader;

  localparam int DWIDTH    = 16;
  localparam int AWIDTH    = 4;
  localparam int BURST_LEN = 8;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              srst;
  logic              enable;
  logic              fifo_empty;
  logic [AWIDTH:0]   fifo_dcount;
  logic [DWIDTH-1:0] fifo_dout_comb;
  logic              fifo_re;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;
  logic              busy;

  // FIFO model: multi-word write port driven by the bench, look-ahead read port.
  logic [DWIDTH-1:0] mem [0:15];
  logic [3:0]        wr_ptr = '0;
  logic [3:0]        rd_ptr = '0;
  logic [AWIDTH:0]   count  = '0;
  int                wr_cnt;
  logic [DWIDTH-1:0] wr_base;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cycle [0:15];

  always #5 clk = ~clk;

  assign fifo_dcount    = count;
  assign fifo_empty     = (count == '0);
  assign fifo_dout_comb = mem[rd_ptr];

  always @(posedge clk) begin
    for (int i = 0; i < wr_cnt; i++) mem[4'(wr_ptr + 4'(i))] <= wr_base + DWIDTH'(i);
    wr_ptr <= wr_ptr + 4'(wr_cnt);
    if (fifo_re) rd_ptr <= rd_ptr + 4'd1;
    count <= count + (AWIDTH+1)'(wr_cnt) - (AWIDTH+1)'(fifo_re);
  end

  sync_fifo_burst_reader #(
    .DWIDTH   (DWIDTH),
    .AWIDTH   (AWIDTH),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_dcount   (fifo_dcount),
    .fifo_dout_comb(fifo_dout_comb),
    .fifo_re       (fifo_re),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] base, input int n);
    wr_base = base;
    wr_cnt  = n;
    tick();
    wr_cnt  = 0;
  endtask

  // Consume n words with m_ready high; last_mask marks which word indices carry m_last.
  task automatic expect_stream(input string name, input logic [15:0] base, input int n,
                               input logic [31:0] last_mask, input int budget);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    m_ready = 1'b1;
    while (k < n && cyc < budget) begin
      #1;
      if (m_valid) begin
        check($sformatf("%s_data%0d", name, k), 32'(m_data), 32'(base + 16'(k)));
        check($sformatf("%s_last%0d", name, k), 32'(m_last), 32'(last_mask[k]));
        hs_cycle[k] = cyc;
        k++;
      end
      if (k < n) begin
        tick();
        cyc++;
      end
    end
    check($sformatf("%s_count", name), 32'(k), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int k;
    srst    = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b1;
    wr_cnt  = 0;
    wr_base = '0;
    @(negedge clk);
    tick();
    tick();

    // Reset state.
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    check("rst_last",  32'(m_last),  32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_re",    32'(fifo_re), 32'd0);
    srst = 1'b0;
    tick();

    // T1: full burst, sink always ready.
    preload(16'h0100, 8);
    enable = 1'b1;
    tick();
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("t1_re%0d", c),   32'(fifo_re), 32'(c < 8));
      check($sformatf("t1_busy%0d", c), 32'(busy),    32'(c < 8));
      if (c > 0) begin
        check($sformatf("t1_valid%0d", c), 32'(m_valid), 32'd1);
        check($sformatf("t1_data%0d", c),  32'(m_data),  32'(16'h0100 + 16'(c - 1)));
        check($sformatf("t1_last%0d", c),  32'(m_last),  32'(c == 8));
      end
      tick();
    end

    // T2: same burst with m_ready toggling 1,0,1,0.
    enable = 1'b0;
    preload(16'h0100, 8);
    enable = 1'b1;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      m_ready = (c % 2 == 0);
      #1;
      check($sformatf("t2_re_stall%0d", c), 32'(fifo_re & m_valid & ~m_ready), 32'd0);
      if (m_valid && m_ready) begin
        check($sformatf("t2_data%0d", k), 32'(m_data), 32'(16'h0100 + 16'(k)));
        check($sformatf("t2_last%0d", k), 32'(m_last), 32'(k == 7));
        k++;
      end
      if (k == 8) break;
      tick();
    end
    check("t2_count", 32'(k), 32'd8);
    m_ready = 1'b1;

    // T3: 3 words sit below threshold and are flushed after 16 WAIT cycles.
    enable = 1'b0;
    preload(16'h00A0, 3);
    enable = 1'b1;
    tick();
    for (int j = 0; j < 16; j++) begin
      check($sformatf("t3_wait_re%0d", j),   32'(fifo_re), 32'd0);
      check($sformatf("t3_wait_busy%0d", j), 32'(busy),    32'd1);
      tick();
    end
    check("t3_flush_re", 32'(fifo_re), 32'd1);
    expect_stream("t3", 16'h00A0, 3, 32'h4, 10);
    tick();
    tick();

    // T4: writer raises dcount to 8 at timer=5; a full burst follows, no flush.
    enable = 1'b0;
    tick();
    preload(16'h0200, 3);
    enable = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) tick();
    check("t4_in_wait", 32'(busy), 32'd1);
    wr_base = 16'h0203;
    wr_cnt  = 5;
    tick();
    wr_cnt  = 0;
    check("t4_dcount8", 32'(fifo_dcount), 32'd8);
    check("t4_still_wait", 32'(fifo_re), 32'd0);
    tick();
    check("t4_burst_re", 32'(fifo_re), 32'd1);
    expect_stream("t4", 16'h0200, 8, 32'h80, 20);
    tick();
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_drained", 32'(fifo_dcount), 32'd0);

    // T5: 4 extra writes as the burst starts; burst stays 8, then WAIT and a 4-word flush.
    enable  = 1'b0;
    preload(16'h0300, 8);
    enable  = 1'b1;
    wr_base = 16'h0308;
    wr_cnt  = 4;
    tick();
    wr_cnt  = 0;
    check("t5_peak", 32'(fifo_dcount), 32'd12);
    expect_stream("t5", 16'h0300, 12, 32'h880, 80);
    check("t5_gap", 32'(hs_cycle[8] - hs_cycle[7]), 32'd18);
    tick();
    tick();

    // T6: reset after the 3rd word of a burst.
    enable = 1'b0;
    tick();
    preload(16'h0400, 8);
    enable = 1'b1;
    found  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_valid && m_data == 16'h0402) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t6_third_word", 32'(found), 32'd1);
    srst    = 1'b1;
    m_ready = 1'b0;
    tick();
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_re",    32'(fifo_re), 32'd0);
    check("t6_busy",  32'(busy),    32'd0);
    check("t6_data",  32'(m_data),  32'd0);
    check("t6_dcount", 32'(fifo_dcount), 32'd5);
    srst    = 1'b0;
    m_ready = 1'b1;
    tick();
    check("t6_wait_busy", 32'(busy),    32'd1);
    check("t6_wait_re",   32'(fifo_re), 32'd0);
    expect_stream("t6", 16'h0403, 5, 32'h10, 40);
    tick();
    tick();
    check("t6_end_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
